// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_pkg : shared UART types, state encoding and parity helper           |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package uart_pkg;

   localparam int UART_MAX_WIDTH = 16;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      ODD  = 2'd1,
      EVEN = 2'd2
   } uart_parity_e;

   typedef struct packed {
      logic overrun;
      logic frame_err;
      logic parity_err;
   } uart_rx_err_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   // Mode encoding 3 is treated as "no parity", same as 0.
   function automatic uart_parity_e uart_decode_parity(input logic [1:0] mode);
      case (mode)
         2'd1:    return ODD;
         2'd2:    return EVEN;
         default: return NONE;
      endcase
   endfunction

   // XOR of the low 'width' bits of data.
   function automatic logic uart_parity(input logic [UART_MAX_WIDTH-1:0] data, input int width);
      logic p;
      p = 1'b0;
      for (int i = 0; i < UART_MAX_WIDTH; i++) begin
         if (i < width) p = p ^ data[i];
      end
      return p;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_majority_sampler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_majority_sampler : rx synchroniser, oversample tick, 3-vote bit     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module uart_majority_sampler #(
   parameter int DIVIDER_WIDTH = 16,
   parameter int OVERSAMPLE    = 16
) (
   input  logic                     i_clk,
   input  logic                     i_arstn,
   input  logic                     i_rx,
   input  logic [DIVIDER_WIDTH-1:0] i_divider,
   input  logic                     i_clear,
   input  logic                     i_run,
   output logic                     o_fall,
   output logic                     o_bit_valid,
   output logic                     o_bit_value
);

   localparam int            SW      = $clog2(OVERSAMPLE);
   localparam logic [SW-1:0] c_VOTE0 = SW'(OVERSAMPLE/2 - 1);
   localparam logic [SW-1:0] c_VOTE1 = SW'(OVERSAMPLE/2);
   localparam logic [SW-1:0] c_VOTE2 = SW'(OVERSAMPLE/2 + 1);
   localparam logic [SW-1:0] c_LAST  = SW'(OVERSAMPLE - 1);

   logic [1:0]               r_sync;
   logic                     r_prev;
   logic [DIVIDER_WIDTH-1:0] r_tick_cnt;
   logic [SW-1:0]            r_samp_cnt;
   logic                     r_vote0;
   logic                     r_vote1;

   logic                     w_rx;
   logic                     w_tick;
   logic [DIVIDER_WIDTH-1:0] w_term;

   assign w_rx   = r_sync[1];
   // >= keeps the counter from running away if the divider shrinks while idle.
   assign w_term = (i_divider <= DIVIDER_WIDTH'(1)) ? '0 : i_divider - DIVIDER_WIDTH'(1);
   assign w_tick = (r_tick_cnt >= w_term);

   always_ff @(posedge i_clk or negedge i_arstn) begin
      if (!i_arstn) begin
         r_sync <= 2'b11;
         r_prev <= 1'b1;
      end else begin
         r_sync <= {r_sync[0], i_rx};
         r_prev <= w_rx;
      end
   end

   always_ff @(posedge i_clk or negedge i_arstn) begin
      if (!i_arstn) begin
         r_tick_cnt <= '0;
      end else if (i_clear || w_tick) begin
         r_tick_cnt <= '0;
      end else begin
         r_tick_cnt <= r_tick_cnt + DIVIDER_WIDTH'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_arstn) begin
      if (!i_arstn) begin
         r_samp_cnt <= '0;
         r_vote0    <= 1'b0;
         r_vote1    <= 1'b0;
      end else if (i_clear || !i_run) begin
         r_samp_cnt <= '0;
      end else if (w_tick) begin
         r_samp_cnt <= (r_samp_cnt == c_LAST) ? '0 : r_samp_cnt + SW'(1);
         if (r_samp_cnt == c_VOTE0) r_vote0 <= w_rx;
         if (r_samp_cnt == c_VOTE1) r_vote1 <= w_rx;
      end
   end

   assign o_fall      = r_prev & ~w_rx;
   assign o_bit_valid = i_run & w_tick & (r_samp_cnt == c_VOTE2);
   assign o_bit_value = (r_vote0 & r_vote1) | (r_vote0 & w_rx) | (r_vote1 & w_rx);

endmodule
`default_nettype wire

// File: rtl/axis_uart_rx_os.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axis_uart_rx_os : oversampling UART receiver with AXI-Stream output      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module axis_uart_rx_os
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int DIVIDER_WIDTH = 16,
   parameter int OVERSAMPLE    = 16
) (
   input  logic                     clk_i,
   input  logic                     arstn_i,
   input  logic [DIVIDER_WIDTH-1:0] clk_divider_i,
   input  logic [1:0]               parity_mode_i,
   input  logic                     stop_bits_i,
   input  logic                     rx_i,
   output logic [DATA_WIDTH-1:0]    m_axis_tdata_o,
   output logic [2:0]               m_axis_tuser_o,
   output logic                     m_axis_tvalid_o,
   input  logic                     m_axis_tready_i,
   output logic                     busy_o
);

   localparam logic [3:0] c_LAST_BIT = 4'(DATA_WIDTH - 1);

   uart_state_e              r_state;
   uart_state_e              w_state_nxt;
   uart_parity_e             r_parity;
   logic                     r_two_stop;
   logic [DIVIDER_WIDTH-1:0] r_div;
   logic [DATA_WIDTH-1:0]    r_shift;
   logic [3:0]               r_bit_cnt;
   logic                     r_stop_cnt;
   logic                     r_frame_err;
   logic                     r_parity_err;
   logic                     r_overrun;
   logic [DATA_WIDTH-1:0]    r_tdata;
   logic [2:0]               r_tuser;
   logic                     r_tvalid;

   logic                     w_fall;
   logic                     w_bit_valid;
   logic                     w_bit_value;
   logic                     w_start;
   logic                     w_done;
   logic                     w_par_calc;
   logic [DIVIDER_WIDTH-1:0] w_div;
   uart_rx_err_t             w_err;

   assign w_start = (r_state == IDLE) && w_fall;
   // Live divider while idle; the captured copy for the rest of the frame.
   assign w_div   = (r_state == IDLE) ? clk_divider_i : r_div;

   uart_majority_sampler #(
      .DIVIDER_WIDTH (DIVIDER_WIDTH),
      .OVERSAMPLE    (OVERSAMPLE)
   ) u_sampler (
      .i_clk       (clk_i),
      .i_arstn     (arstn_i),
      .i_rx        (rx_i),
      .i_divider   (w_div),
      .i_clear     (w_start),
      .i_run       (r_state != IDLE),
      .o_fall      (w_fall),
      .o_bit_valid (w_bit_valid),
      .o_bit_value (w_bit_value)
   );

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_done      = 1'b0;
      case (r_state)
         IDLE:   if (w_fall) w_state_nxt = START;
         START:  if (w_bit_valid) w_state_nxt = w_bit_value ? IDLE : DATA;
         DATA: begin
            if (w_bit_valid && (r_bit_cnt == c_LAST_BIT))
               w_state_nxt = (r_parity != NONE) ? PARITY : STOP;
         end
         PARITY: if (w_bit_valid) w_state_nxt = STOP;
         STOP: begin
            // Leave on the last stop vote so a back-to-back start edge is caught.
            if (w_bit_valid && (r_stop_cnt == r_two_stop)) begin
               w_state_nxt = IDLE;
               w_done      = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_par_calc = uart_parity(UART_MAX_WIDTH'(r_shift), DATA_WIDTH) ^ w_bit_value;

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         r_parity     <= NONE;
         r_two_stop   <= 1'b0;
         r_div        <= '0;
         r_shift      <= '0;
         r_bit_cnt    <= '0;
         r_stop_cnt   <= 1'b0;
         r_frame_err  <= 1'b0;
         r_parity_err <= 1'b0;
      end else if (w_start) begin
         r_parity     <= uart_decode_parity(parity_mode_i);
         r_two_stop   <= stop_bits_i;
         r_div        <= clk_divider_i;
         r_bit_cnt    <= '0;
         r_stop_cnt   <= 1'b0;
         r_frame_err  <= 1'b0;
         r_parity_err <= 1'b0;
      end else if (w_bit_valid) begin
         case (r_state)
            DATA: begin
               r_shift   <= {w_bit_value, r_shift[DATA_WIDTH-1:1]};
               r_bit_cnt <= r_bit_cnt + 4'd1;
            end
            PARITY: r_parity_err <= (r_parity == ODD) ? ~w_par_calc : w_par_calc;
            STOP: begin
               if (!w_bit_value) r_frame_err <= 1'b1;
               r_stop_cnt <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign w_err.overrun    = r_overrun;
   assign w_err.frame_err  = r_frame_err | ~w_bit_value;
   assign w_err.parity_err = r_parity_err;

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         r_tdata   <= '0;
         r_tuser   <= '0;
         r_tvalid  <= 1'b0;
         r_overrun <= 1'b0;
      end else if (w_done) begin
         if (!r_tvalid || m_axis_tready_i) begin
            r_tdata   <= r_shift;
            r_tuser   <= w_err;
            r_tvalid  <= 1'b1;
            r_overrun <= 1'b0;
         end else begin
            r_overrun <= 1'b1;
         end
      end else if (m_axis_tready_i) begin
         r_tvalid <= 1'b0;
      end
   end

   assign m_axis_tdata_o  = r_tdata;
   assign m_axis_tuser_o  = r_tuser;
   assign m_axis_tvalid_o = r_tvalid;
   assign busy_o          = (r_state != IDLE);

endmodule
`default_nettype wire
